muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide unit for the EX stage. It sits alongside the ALU, takes the same two register operands, and owns the architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU over 33 cycles, and also services MTHI/MTLO writes. The hazard unit uses `busy` to stall MFHI/MFLO and any further mul/div until the result is committed.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width. Only 32 is supported.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin an operation. Sampled only in IDLE.
- `op`, in, 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `data1`, in, 32: rs operand (multiplicand / dividend). Also the MTHI/MTLO write data.
- `data2`, in, 32: rt operand (multiplier / divisor).
- `hi_we`, in, 1: MTHI write enable.
- `lo_we`, in, 1: MTLO write enable.
- `flush`, in, 1: abort any in-flight operation (exception or branch squash).
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse; HI/LO already hold the new result.
- `hi`, out, 32: architectural HI register.
- `lo`, out, 32: architectural LO register.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE → CALC** on `start & !flush`:
  - latch the operand magnitudes: absolute value for signed ops, raw value for unsigned;
  - latch the result signs: product/quotient sign = `data1[31]^data2[31]` (signed only); remainder sign = `data1[31]` (signed only);
  - clear the 5-bit step counter.
- **CALC:** one radix-2 step per cycle for 32 cycles (counter 0..31).
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring step on a 64-bit {remainder, quotient} register.
- **CALC → DONE** at the edge where counter = 31. On that edge HI/LO are written with sign correction:
  - multiply: {HI,LO} = signed/unsigned 64-bit product;
  - divide: LO = quotient, HI = remainder.
- **DONE → IDLE** unconditionally after one cycle. `done` = (state==DONE).
- **Divide by zero:** no trap. Result is fixed: LO = 0xFFFFFFFF, HI = `data1` (the raw dividend), for both DIV and DIVU.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, with no flag.
- **MTHI/MTLO:** `hi_we`/`lo_we` write `data1` to HI/LO in IDLE only. They are ignored when `busy` is high; the hazard unit guarantees they never arrive while busy.
- **`start` outside IDLE:** ignored.
- **`flush`:**
  - in CALC or DONE: forces IDLE next edge; HI/LO keep their pre-operation values (a result not yet written is discarded; one already written in DONE stays);
  - in IDLE: blocks a same-cycle `start`, and has priority over `hi_we`/`lo_we`.
- **`rst_n` low at any time:** state IDLE, counter 0, HI = LO = 0, `busy` = `done` = 0, working registers 0. This takes effect immediately, without waiting for a clock edge.

## Timing
- Cycle 0: `start` high in IDLE.
- Cycles 1–32: CALC, `busy` = 1.
- Cycle 33: DONE, `busy` = 1, `done` = 1, new `hi`/`lo` visible.
- Cycle 34: IDLE. A new `start` is accepted in this cycle, giving a 34-cycle issue interval.
- Operands are only needed in cycle 0. `data1`/`data2` may change from cycle 1 onward.
- `hi`/`lo` are direct register outputs with no combinational path from the inputs.
- MTHI/MTLO take effect in the cycle after the enable is asserted.

## Structure
- **Package `muldiv_pkg`:**
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - state enum `{S_IDLE, S_CALC, S_DONE}`;
  - `WIDTH`;
  - constant `STEPS` = 32.
- **Sub-module:** none required. The per-cycle step is one combinational function of (op class, accumulator, operand), kept inside `muldiv_unit`.
- **Final-result formation:** sign correction is a two's-complement negate of the 64-bit multiply result, or of each 32-bit divide half separately.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → `done` at cycle 33; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; `busy` high in cycles 1–33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV 0xFFFFFFF9 (−7) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 7 / 2 → LO = 3, HI = 1.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5.
- MTHI 0x12345678 in IDLE, then MULT 2 × 3, with `flush` asserted in cycle 10 → IDLE in cycle 11; HI = 0x12345678, LO unchanged; `done` never pulses.
- `rst_n` pulsed low asynchronously mid-CALC → `busy` drops immediately; HI = LO = 0; the next `start` runs normally; `start` asserted while `busy` is ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int STEPS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One step per cycle for 32 cycles on magnitudes; signs are fixed up at commit.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import muldiv_pkg::*;

  localparam int DW = 2 * WIDTH;

  state_e           state, state_next;
  logic [4:0]       cnt;
  logic [DW-1:0]    acc;
  logic [DW-1:0]    acc_step;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic             res_neg;
  logic             rem_neg;

  // Multiply: acc = {partial_hi, remaining multiplier bits}, add then shift right.
  // Divide:   acc = {remainder, dividend/quotient bits}, shift left then trial-subtract.
  function automatic logic [DW-1:0] step_fn(input logic             div_op,
                                            input logic [DW-1:0]    a,
                                            input logic [WIDTH-1:0] m);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    sum  = '0;
    diff = '0;
    if (div_op) begin
      diff = a[DW-1:WIDTH-1] - {1'b0, m};
      if (diff[WIDTH]) step_fn = {a[DW-2:0], 1'b0};
      else             step_fn = {diff[WIDTH-1:0], a[WIDTH-2:0], 1'b1};
    end else begin
      sum     = {1'b0, a[DW-1:WIDTH]} + (a[0] ? {1'b0, m} : '0);
      step_fn = {sum, a[WIDTH-1:1]};
    end
  endfunction

  // Operand conditioning, only meaningful in the cycle start is accepted.
  logic             signed_op;
  logic             div_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign div_zero  = (data2 == '0);
  assign a_mag     = (signed_op && data1[WIDTH-1]) ? -data1 : data1;
  assign b_mag     = (signed_op && data2[WIDTH-1]) ? -data2 : data2;

  assign acc_step = step_fn(is_div, acc, opnd);

  // Sign correction applied to the final step's result as it is committed.
  logic [DW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] hi_final;
  logic [WIDTH-1:0] lo_final;

  assign prod_fix = res_neg ? -acc_step : acc_step;
  assign quo_fix  = res_neg ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  assign rem_fix  = rem_neg ? -acc_step[DW-1:WIDTH] : acc_step[DW-1:WIDTH];
  assign hi_final = is_div ? rem_fix : prod_fix[DW-1:WIDTH];
  assign lo_final = is_div ? quo_fix : prod_fix[WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (start && !flush) state_next = S_CALC;
      S_CALC: begin
        if (flush)                         state_next = S_IDLE;
        else if (cnt == 5'(STEPS - 1))     state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: working registers are reset too, not just control, so a reset
  // mid-operation leaves no stale accumulator or sign state behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!flush) begin
            if (start) begin
              cnt    <= '0;
              is_div <= op[1];
              if (op[1]) begin
                acc  <= {{WIDTH{1'b0}}, a_mag};
                opnd <= b_mag;
              end else begin
                acc  <= {{WIDTH{1'b0}}, b_mag};
                opnd <= a_mag;
              end
              // Divide by zero must yield an all-ones quotient for DIV too.
              res_neg <= signed_op && (data1[WIDTH-1] ^ data2[WIDTH-1]) &&
                         !(op[1] && div_zero);
              rem_neg <= signed_op && data1[WIDTH-1];
            end
            if (hi_we) hi <= data1;
            if (lo_we) lo <= data1;
          end
        end
        S_CALC: begin
          if (!flush) begin
            acc <= acc_step;
            cnt <= cnt + 5'd1;
            if (cnt == 5'(STEPS - 1)) begin
              hi <= hi_final;
              lo <= lo_final;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: cycle-level arithmetic model compared every cycle,
// plus directed operations with hand-computed HI/LO results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .data1(data1), .data2(data2), .hi_we(hi_we), .lo_we(lo_we),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, as {HI, LO}.
  function automatic logic [63:0] model_result(input logic [1:0] o,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: return sa * sb;
      2'b01: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end else return {a % b, a / b};
      end
    endcase
  endfunction

  // Model: m_cyc counts cycles since the accepting start (0 = idle, 33 = done).
  int          m_cyc  = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc <= 0;
      m_hi  <= '0;
      m_lo  <= '0;
    end else if (m_cyc == 0) begin
      if (!flush) begin
        if (start) begin
          m_cyc  <= 1;
          m_pend <= model_result(op, data1, data2);
        end
        if (hi_we) m_hi <= data1;
        if (lo_we) m_lo <= data1;
      end
    end else if (flush) begin
      m_cyc <= 0;
    end else if (m_cyc == 32) begin
      m_cyc <= 33;
      m_hi  <= m_pend[63:32];
      m_lo  <= m_pend[31:0];
    end else if (m_cyc == 33) begin
      m_cyc <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_cyc != 0);
    check("done", done, m_cyc == 33);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  end

  // Issues one op at the next cycle; returns during its done cycle, so the
  // following call lands in the first cycle a new start is accepted.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string name, input bit poke);
    int cyc;
    @(posedge clk); #1;
    start = 1'b1; op = o; data1 = a; data2 = b;
    @(posedge clk); #1;
    start = 1'b0; data1 = $urandom; data2 = $urandom;
    cyc = 1;
    check({name, "_busy_c1"}, busy, 1'b1);
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      start = poke && (cyc == 5);
      if (poke && cyc == 5) begin op = OP_DIVU; data1 = 32'd7; data2 = 32'd2; end
    end
    check({name, "_done_cycle"}, cyc, 33);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int  cyc;
    bit  seen_done;

    #2 rst_n = 1'b0;
    #10;
    @(posedge clk); #1 rst_n = 1'b1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);

    run_op(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg", 0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minmin", 0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2", 0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, "div_neg7_neg2", 0);
    run_op(OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         "divu_7_2", 0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf", 0);
    run_op(OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, "divu_by0", 0);
    run_op(OP_DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, "div_neg_by0", 0);
    run_op(OP_MULTU, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001, 32'h0002_0001, "start_while_busy", 1);

    // MTHI then a flushed MULT: HI/LO keep their pre-operation values.
    @(posedge clk); #1;
    hi_we = 1'b1; data1 = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'h1234_5678);
    start = 1'b1; op = OP_MULT; data1 = 32'd2; data2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    seen_done = 0;
    while (cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen_done = 1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle_c11", busy, 1'b0);
    check("flush_hi", hi, 32'h1234_5678);
    check("flush_lo", lo, 32'h0002_0001);
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
    end
    check("flush_no_done", seen_done, 1'b0);

    // Asynchronous reset in the middle of CALC.
    start = 1'b1; op = OP_MULT; data1 = 32'd5; data2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    check("areset_busy", busy, 1'b0);
    check("areset_done", done, 1'b0);
    check("areset_hi", hi, 32'h0);
    check("areset_lo", lo, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_op(OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6, "after_reset", 0);

    // Flush in IDLE blocks start and wins over MTHI/MTLO.
    @(posedge clk); #1;
    start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; flush = 1'b1; data1 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0;
    check("idle_flush_busy", busy, 1'b0);
    check("idle_flush_hi", hi, 32'h0);
    check("idle_flush_lo", lo, 32'd6);

    // MTLO alone takes effect the next cycle.
    lo_we = 1'b1; data1 = 32'hCAFE_0001;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'hCAFE_0001);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
